fifo_rd_streamer: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_skid_buf.sv | 68 ++++++
 rtl/fifo_rd_streamer.sv | 64 ++++++
 tb/tb_fifo_rd_streamer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared sizing defaults and skid-buffer occupancy encoding for the FIFO read-side streamer.
package fifo_rd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register skid buffer; the head entry is always the presented word.
//   state     | meaning
//   OCC_EMPTY | no word held, valid low
//   OCC_ONE   | head holds the only word
//   OCC_TWO   | head presented, tail waiting behind it
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output occ_t             occ
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      unique case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head <= push_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail <= push_data;
            occ  <= OCC_TWO;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head <= tail;
            occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  assign head_data = head;
  assign valid     = (occ != OCC_EMPTY);

  // The credit rule upstream must never let a word land on a full buffer.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rst)
    !(occ == OCC_TWO && push));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-domain FIFO consumer: credit-limited pops, one-cycle read latency tracking,
// valid/ready output through a 2-entry skid buffer, flush and delivered-word counter.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             empty_flag,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] rd_count
);

  occ_t       occ;
  logic       inflight;
  logic       leave;
  logic [2:0] credit;

  assign leave = m_valid && m_ready;

  // Words held plus the word on the read bus, less the one leaving this edge.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, leave};
  assign rd_en  = rst && !empty_flag && !flush && (credit < 3'd2);

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
    end else if (leave && !flush) begin
      rd_count <= rd_count + CNT_W'(1);
    end
  end

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (leave && !flush),
    .flush     (flush),
    .head_data (m_data),
    .valid     (m_valid),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: FIFO model feeds words, a scoreboard queue checks delivery order.
module tb_fifo_rd_streamer;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b0;
  logic        empty_flag;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_en, rd_en4;
  logic [7:0]  m_data, m_data4;
  logic        m_valid, m_valid4;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_mem [0:255];
  int         n_push = 0;
  int         n_pop  = 0;
  logic [7:0] exp_q [$];

  always #5 rd_clk = ~rd_clk;

  assign empty_flag = (n_push == n_pop);

  fifo_rd_streamer #(.WIDTH(8), .CNT_W(16)) u_dut (
    .rd_clk(rd_clk), .rst(rst), .empty_flag(empty_flag), .rd_data(rd_data),
    .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .rd_count(rd_count)
  );

  fifo_rd_streamer #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .rd_clk(rd_clk), .rst(rst), .empty_flag(empty_flag), .rd_data(rd_data),
    .rd_en(rd_en4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .flush(flush), .rd_count(rd_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency; upstream is reset together with the DUT.
  always @(posedge rd_clk) begin
    if (!rst) begin
      n_pop <= n_push;
    end else if (rd_en && !empty_flag) begin
      rd_data <= fifo_mem[n_pop];
      n_pop   <= n_pop + 1;
    end
  end

  logic       p_valid = 1'b0, p_ready = 1'b0, p_flush = 1'b0, p_rst = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(negedge rd_clk) begin
    if (rst) begin
      chk("no_pop_empty", {31'b0, rd_en & empty_flag}, 32'd0);
      chk("no_pop_empty4", {31'b0, rd_en4 & empty_flag}, 32'd0);
      if (p_rst && p_valid && !p_ready && !p_flush) begin
        chk("hold_valid", {31'b0, m_valid}, 32'd1);
        chk("hold_data", {24'b0, m_data}, {24'b0, p_data});
      end
      if (m_valid && m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_word: got 'h%0h, expected no word at %0t", m_data, $time);
        end else begin
          chk("m_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
        end
      end
    end
    p_valid <= m_valid;
    p_ready <= m_ready;
    p_flush <= flush;
    p_rst   <= rst;
    p_data  <= m_data;
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    fifo_mem[n_push] = w;
    exp_q.push_back(w);
    n_push++;
  endtask

  task automatic drain(input logic [7:0] pat, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      m_ready = pat[c % 8];
      tick();
      c++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
    m_ready = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic [7:0]  start;
    int          n;
    logic [7:0]  pat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];
  int   p0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{start: 8'h20, n: 5,  pat: 8'hFF, exp_cnt: 16'd22};
    vecs[1] = '{start: 8'h40, n: 9,  pat: 8'h55, exp_cnt: 16'd31};
    vecs[2] = '{start: 8'h60, n: 4,  pat: 8'h01, exp_cnt: 16'd35};
    vecs[3] = '{start: 8'hF8, n: 12, pat: 8'hF0, exp_cnt: 16'd47};
    vecs[4] = '{start: 8'h99, n: 1,  pat: 8'hAA, exp_cnt: 16'd48};

    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", {24'b0, m_data}, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
    chk("rst_rd_count", {16'b0, rd_count}, 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Idle with an empty FIFO
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_rd_en", {31'b0, rd_en}, 32'd0);
      chk("idle_m_valid", {31'b0, m_valid}, 32'd0);
      chk("idle_rd_count", {16'b0, rd_count}, 32'd0);
    end

    // Single word latency
    m_ready = 1'b1;
    load(8'h11);
    #1;
    chk("single_rd_en_c0", {31'b0, rd_en}, 32'd1);
    chk("single_valid_c0", {31'b0, m_valid}, 32'd0);
    tick();
    chk("single_rd_en_c1", {31'b0, rd_en}, 32'd0);
    chk("single_valid_c1", {31'b0, m_valid}, 32'd0);
    tick();
    chk("single_valid_c2", {31'b0, m_valid}, 32'd1);
    chk("single_data_c2", {24'b0, m_data}, 32'h11);
    tick();
    chk("single_valid_c3", {31'b0, m_valid}, 32'd0);
    chk("single_count", {16'b0, rd_count}, 32'd1);

    // Back-to-back 16 words, full throughput
    p0 = n_pop;
    for (int i = 0; i < 16; i++) load(8'(8'h11 + (i * 188) / 15));
    #1;
    for (int c = 0; c < 20; c++) begin
      chk("b2b_rd_en", {31'b0, rd_en}, (c < 16) ? 32'd1 : 32'd0);
      chk("b2b_m_valid", {31'b0, m_valid}, (c >= 2 && c < 18) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b2b_pops", n_pop - p0, 32'd16);
    chk("b2b_count", {16'b0, rd_count}, 32'd17);
    chk("b2b_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: only two pops while stalled
    m_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 7; i++) load(8'((i + 1) * 16));
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("bp_rd_en", {31'b0, rd_en}, (c < 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("bp_pops", n_pop - p0, 32'd2);
    chk("bp_m_valid", {31'b0, m_valid}, 32'd1);
    chk("bp_m_data", {24'b0, m_data}, 32'h10);
    drain(8'hFF, 40);
    chk("bp_all_pops", n_pop - p0, 32'd7);
    chk("bp_count", {16'b0, rd_count}, 32'd24);

    // Flush with one word buffered and one in flight
    load(8'hA0);
    load(8'hA1);
    load(8'hA2);
    tick();
    tick();
    flush = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #1;
    chk("fl1_rd_en", {31'b0, rd_en}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl1_valid_c3", {31'b0, m_valid}, 32'd0);
    chk("fl1_rd_en_c3", {31'b0, rd_en}, 32'd1);
    chk("fl1_count", {16'b0, rd_count}, 32'd24);
    tick();
    chk("fl1_valid_c4", {31'b0, m_valid}, 32'd0);
    tick();
    chk("fl1_valid_c5", {31'b0, m_valid}, 32'd1);
    chk("fl1_data_c5", {24'b0, m_data}, 32'hA2);
    drain(8'hFF, 20);
    chk("fl1_count_after", {16'b0, rd_count}, 32'd25);

    // Flush with a full buffer and a simultaneous transfer: flush wins
    p0 = n_pop;
    load(8'hB0);
    load(8'hB1);
    load(8'hB2);
    tick();
    tick();
    tick();
    chk("fl2_valid", {31'b0, m_valid}, 32'd1);
    chk("fl2_data", {24'b0, m_data}, 32'hB0);
    chk("fl2_pops", n_pop - p0, 32'd2);
    m_ready = 1'b1;
    flush = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #1;
    chk("fl2_rd_en", {31'b0, rd_en}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl2_valid_after", {31'b0, m_valid}, 32'd0);
    chk("fl2_count", {16'b0, rd_count}, 32'd25);
    chk("fl2_rd_en_after", {31'b0, rd_en}, 32'd1);
    tick();
    tick();
    chk("fl2_valid_b2", {31'b0, m_valid}, 32'd1);
    chk("fl2_data_b2", {24'b0, m_data}, 32'hB2);
    drain(8'hFF, 20);
    chk("fl2_count_after", {16'b0, rd_count}, 32'd26);

    // Reset mid-stream with the buffer holding a word
    load(8'hC0);
    load(8'hC1);
    load(8'hC2);
    tick();
    tick();
    chk("mr_valid_pre", {31'b0, m_valid}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mr_m_valid", {31'b0, m_valid}, 32'd0);
    chk("mr_m_data", {24'b0, m_data}, 32'd0);
    chk("mr_rd_en", {31'b0, rd_en}, 32'd0);
    chk("mr_rd_count", {16'b0, rd_count}, 32'd0);
    chk("mr_rd_count4", {28'b0, rd_count4}, 32'd0);
    tick();
    chk("mr_valid_hold", {31'b0, m_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) load(8'(i * 3 + 5));
    drain(8'hFF, 60);
    chk("wrap_count16", {16'b0, rd_count}, 32'd17);
    chk("wrap_count4", {28'b0, rd_count4}, 32'd1);

    // Table-driven streaming runs under assorted m_ready patterns
    for (int v = 0; v < 5; v++) begin
      p0 = n_pop;
      for (int i = 0; i < vecs[v].n; i++) load(vecs[v].start + 8'(i));
      drain(vecs[v].pat, 200);
      chk("vec_pops", n_pop - p0, vecs[v].n);
      chk("vec_count", {16'b0, rd_count}, {16'b0, vecs[v].exp_cnt});
      chk("vec_count4", {28'b0, rd_count4}, {28'b0, vecs[v].exp_cnt[3:0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
